// File: rtl/memory_arbiter_pkg.sv
// Shared types for the icache/dcache to RAM arbiter.
package memory_arbiter_pkg;

   typedef enum logic [1:0] {
      RAM_FREE   = 2'd0,
      RAM_BUSY   = 2'd1,
      RAM_ACCESS = 2'd2,
      RAM_ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IACC = 2'd1,
      DACC = 2'd2,
      DONE = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates one shared RAM port between icache reads and dcache reads/writes,
// with round-robin fairness, RAM error handling and a per-access timeout.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              iwait,
   output logic              dwait,
   output logic [DATA_W-1:0] iload,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [1:0]        ramstate,
   input  logic [DATA_W-1:0] ramload,
   output logic              err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   arb_state_t        state;
   grant_t            grant;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] iload_q;
   logic [DATA_W-1:0] dload_q;
   logic              ren_q;
   logic              wen_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] store_q;
   logic              err_q;
   logic              d_req;
   ramstate_t         rs;

   assign d_req = dREN | dWEN;
   assign rs    = ramstate_t'(ramstate);

   assign iwait = iREN  & ~(state == DONE && grant == GRANT_I);
   assign dwait = d_req & ~(state == DONE && grant == GRANT_D);

   assign iload    = iload_q;
   assign dload    = dload_q;
   assign ramREN   = ren_q;
   assign ramWEN   = wen_q;
   assign ramaddr  = addr_q;
   assign ramstore = store_q;
   assign err      = err_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         grant   <= GRANT_D;
         cnt     <= '0;
         iload_q <= '0;
         dload_q <= '0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         store_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state)
            IDLE: begin
               // dcache wins unless it also won the previous grant
               if (d_req && !(iREN && grant == GRANT_D)) begin
                  state   <= DACC;
                  grant   <= GRANT_D;
                  cnt     <= '0;
                  ren_q   <= dREN;
                  wen_q   <= dWEN;
                  addr_q  <= daddr;
                  store_q <= dstore;
               end else if (iREN) begin
                  state   <= IACC;
                  grant   <= GRANT_I;
                  cnt     <= '0;
                  ren_q   <= 1'b1;
                  wen_q   <= 1'b0;
                  addr_q  <= iaddr;
                  store_q <= '0;
               end
            end
            IACC, DACC: begin
               cnt <= cnt + 1'b1;
               if (rs == RAM_ACCESS) begin
                  state <= DONE;
                  ren_q <= 1'b0;
                  wen_q <= 1'b0;
                  if (ren_q && state == IACC) iload_q <= ramload;
                  if (ren_q && state == DACC) dload_q <= ramload;
               end else if (rs == RAM_ERROR || cnt == LAST) begin
                  state <= DONE;
                  ren_q <= 1'b0;
                  wen_q <= 1'b0;
                  err_q <= 1'b1;
                  if (state == IACC) iload_q <= '0;
                  else               dload_q <= '0;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed checks of the memory arbiter: latency, fairness, writes,
// RAM error, timeout, reset abort and mid-access request drop.
module tb_memory_arbiter;
   import memory_arbiter_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore;
   logic        iwait, dwait;
   logic [31:0] iload, dload;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore;
   logic [1:0]  ramstate;
   logic [31:0] ramload;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN),
      .ramaddr(ramaddr), .ramstore(ramstore),
      .ramstate(ramstate), .ramload(ramload), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0;
      ramstate = RAM_FREE; ramload = 0;
      tick(); tick();
      chk("rst_ren",   32'(ramREN), 0);
      chk("rst_wen",   32'(ramWEN), 0);
      chk("rst_addr",  ramaddr, 0);
      chk("rst_store", ramstore, 0);
      chk("rst_err",   32'(err), 0);
      chk("rst_iload", iload, 0);
      chk("rst_dload", dload, 0);
      chk("rst_iwait", 32'(iwait), 0);
      RST = 0;
      tick();

      // icache read, RAM answers on first strobe
      ramstate = RAM_ACCESS; ramload = 32'hDEADBEEF;
      iREN = 1; iaddr = 32'h10;
      #1 chk("i_c1_wait", 32'(iwait), 1);
      tick();
      chk("i_c2_wait", 32'(iwait), 1);
      chk("i_c2_ren",  32'(ramREN), 1);
      chk("i_c2_addr", ramaddr, 32'h10);
      tick();
      chk("i_c3_wait",  32'(iwait), 0);
      chk("i_c3_load",  iload, 32'hDEADBEEF);
      chk("i_c3_ren",   32'(ramREN), 0);
      chk("i_c3_err",   32'(err), 0);
      iREN = 0;
      tick();

      // dcache write held until ACCESS, registered address
      ramstate = RAM_BUSY;
      dWEN = 1; daddr = 32'h20; dstore = 32'h1234;
      tick();
      chk("w_wen",   32'(ramWEN), 1);
      chk("w_ren",   32'(ramREN), 0);
      chk("w_addr",  ramaddr, 32'h20);
      chk("w_store", ramstore, 32'h1234);
      chk("w_wait",  32'(dwait), 1);
      daddr = 32'h99; dstore = 32'h5555;
      tick();
      chk("w_hold_wen",   32'(ramWEN), 1);
      chk("w_hold_addr",  ramaddr, 32'h20);
      chk("w_hold_store", ramstore, 32'h1234);
      ramstate = RAM_ACCESS;
      tick();
      chk("w_done_wait", 32'(dwait), 0);
      chk("w_done_wen",  32'(ramWEN), 0);
      chk("w_done_load", dload, 0);
      dWEN = 0;
      tick();

      // dcache read success
      dREN = 1; daddr = 32'h30; ramload = 32'hCAFEF00D;
      tick();
      chk("r_ren", 32'(ramREN), 1);
      tick();
      chk("r_wait", 32'(dwait), 0);
      chk("r_load", dload, 32'hCAFEF00D);
      dREN = 0;
      tick();

      // timeout after 4 BUSY access cycles
      dREN = 1; ramstate = RAM_BUSY;
      tick();
      chk("to_c1_err", 32'(err), 0);
      tick(); tick(); tick();
      chk("to_c4_wait", 32'(dwait), 1);
      chk("to_c4_ren",  32'(ramREN), 1);
      tick();
      chk("to_done_wait", 32'(dwait), 0);
      chk("to_done_load", dload, 0);
      chk("to_done_err",  32'(err), 1);
      dREN = 0;
      tick();
      chk("to_err_off", 32'(err), 0);

      // read success then RAM ERROR on dcache read
      dREN = 1; ramstate = RAM_ACCESS; ramload = 32'h55AA;
      tick(); tick();
      chk("r2_load", dload, 32'h55AA);
      dREN = 0;
      tick();
      dREN = 1; ramstate = RAM_ERROR;
      tick();
      chk("e_wait_acc", 32'(dwait), 1);
      chk("e_err_acc",  32'(err), 0);
      tick();
      chk("e_wait", 32'(dwait), 0);
      chk("e_load", dload, 0);
      chk("e_err",  32'(err), 1);
      tick();
      chk("e_wait_after", 32'(dwait), 1);
      chk("e_err_after",  32'(err), 0);
      dREN = 0;
      tick(); tick(); tick();

      // fairness from reset: icache first, dcache DONE at cycle 6
      RST = 1; ramstate = RAM_ACCESS; ramload = 32'h11111111;
      iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h50;
      tick();
      RST = 0;
      tick();
      chk("f_c2_addr",  ramaddr, 32'h40);
      chk("f_c2_dwait", 32'(dwait), 1);
      tick();
      chk("f_c3_iwait", 32'(iwait), 0);
      chk("f_c3_dwait", 32'(dwait), 1);
      chk("f_c3_iload", iload, 32'h11111111);
      iREN = 0; ramload = 32'h22222222;
      tick();
      chk("f_c4_dwait", 32'(dwait), 1);
      chk("f_c4_ren",   32'(ramREN), 0);
      tick();
      chk("f_c5_addr",  ramaddr, 32'h50);
      chk("f_c5_dwait", 32'(dwait), 1);
      tick();
      chk("f_c6_dwait", 32'(dwait), 0);
      chk("f_c6_dload", dload, 32'h22222222);
      dREN = 0;
      tick();

      // reset during a BUSY dcache access
      dREN = 1; ramstate = RAM_BUSY;
      tick(); tick();
      chk("ra_ren_pre", 32'(ramREN), 1);
      RST = 1;
      tick();
      chk("ra_ren",   32'(ramREN), 0);
      chk("ra_wen",   32'(ramWEN), 0);
      chk("ra_err",   32'(err), 0);
      chk("ra_dwait", 32'(dwait), 1);
      chk("ra_dload", dload, 0);
      RST = 0; dREN = 0;
      tick();
      chk("ra_err2", 32'(err), 0);

      // icache drops request mid-access; access still completes
      iREN = 1; iaddr = 32'h60; ramstate = RAM_BUSY;
      tick();
      iREN = 0;
      tick();
      chk("dr_ren",   32'(ramREN), 1);
      chk("dr_iwait", 32'(iwait), 0);
      ramstate = RAM_ACCESS; ramload = 32'h77;
      tick();
      chk("dr_done_ren", 32'(ramREN), 0);
      chk("dr_iload",    iload, 32'h77);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
